// File: rtl/tcdm_starve_sched_if.sv
// Request/grant bundle seen by the starvation scheduler: master side, network
// side, and the observed bank-side handshake used for priority advancement.
interface tcdm_starve_sched_if #(
    parameter int unsigned NumIn  = 32,
    parameter int unsigned NumOut = 32
);
    logic [NumIn-1:0]  req;
    logic [NumIn-1:0]  gnt;
    logic [NumIn-1:0]  net_req;
    logic [NumIn-1:0]  net_gnt;
    logic [NumOut-1:0] slv_req;
    logic [NumOut-1:0] slv_gnt;

    modport master (
        output req,
        output net_gnt,
        output slv_req,
        output slv_gnt,
        input  gnt,
        input  net_req
    );

    modport slave (
        input  req,
        input  net_gnt,
        input  slv_req,
        input  slv_gnt,
        output gnt,
        output net_req
    );
endinterface

// File: rtl/tcdm_starve_sched.sv
// Starvation-aware request scheduler for a butterfly TCDM interconnect: drives
// the shared priority vector and boosts any master whose request waits too long.
module tcdm_starve_sched #(
    parameter int unsigned  NumIn        = 32,
    parameter int unsigned  NumOut       = 32,
    parameter int unsigned  StarveThresh = 15,
    localparam int unsigned RrWidth      = $clog2(NumOut),
    localparam int unsigned IdxWidth     = $clog2(NumIn),
    localparam int unsigned CntWidth     = $clog2(StarveThresh + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    tcdm_starve_sched_if.slave  bus,
    input  logic                cfg_fix_en_i,
    input  logic [RrWidth-1:0]  cfg_rr_i,
    output logic [RrWidth-1:0]  rr_o,
    output logic                boost_o,
    output logic [IdxWidth-1:0] boost_idx_o,
    output logic [15:0]         boost_cnt_o
);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_BOOST  = 1'b1
    } state_e;

    localparam logic [CntWidth-1:0] ThreshVal = CntWidth'(StarveThresh);
    localparam logic [NumIn-1:0]    OneHot0   = {{(NumIn-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic [IdxWidth-1:0]  sel_q, sel_d;
    logic [IdxWidth-1:0]  ptr_q, ptr_d;
    logic [RrWidth-1:0]   rr_q, rr_d;
    logic [15:0]          boost_cnt_q, boost_cnt_d;
    logic [CntWidth-1:0]  cnt_q [NumIn];
    logic [CntWidth-1:0]  cnt_d [NumIn];

    logic [NumIn-1:0]     mask_s;
    logic [NumIn-1:0]     starve_s;
    logic [IdxWidth-1:0]  sel_s;
    logic                 found_s;

    // Mask derives only from registered state, so net_gnt never loops back into net_req.
    always_comb begin
        mask_s = '0;
        if (state_q == ST_BOOST) begin
            mask_s = ~(OneHot0 << sel_q);
        end else begin
            mask_s = '0;
        end
    end

    assign bus.net_req = bus.req & ~mask_s;
    assign bus.gnt     = bus.net_gnt & ~mask_s;

    // Per-master wait counters; they keep running while masked so a held-off
    // master still accrues wait time.
    always_comb begin
        starve_s = '0;
        for (int i = 0; i < NumIn; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.req[i] && !bus.gnt[i]) begin
                if (cnt_q[i] == ThreshVal) begin
                    cnt_d[i] = cnt_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntWidth'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
            starve_s[i] = (cnt_q[i] == ThreshVal) && bus.req[i];
        end
    end

    // Rotating first-set search over the starving set, starting at ptr_q.
    always_comb begin : p_select
        logic [IdxWidth-1:0] cand;
        cand    = '0;
        sel_s   = '0;
        found_s = 1'b0;
        for (int k = 0; k < NumIn; k++) begin
            cand = ptr_q + IdxWidth'(k);
            if (!found_s && starve_s[cand]) begin
                sel_s   = cand;
                found_s = 1'b1;
            end else begin
                sel_s   = sel_s;
                found_s = found_s;
            end
        end
    end

    // Next-state logic for the NORMAL/BOOST machine and the priority counter.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        rr_d        = rr_q;
        boost_cnt_d = boost_cnt_q;
        case (state_q)
            ST_NORMAL: begin
                if (found_s) begin
                    state_d = ST_BOOST;
                    sel_d   = sel_s;
                    if (boost_cnt_q != 16'hFFFF) begin
                        boost_cnt_d = boost_cnt_q + 16'd1;
                    end else begin
                        boost_cnt_d = boost_cnt_q;
                    end
                end else begin
                    state_d = ST_NORMAL;
                end
                if (|(bus.slv_req & bus.slv_gnt)) begin
                    rr_d = rr_q + RrWidth'(1);
                end else begin
                    rr_d = rr_q;
                end
            end
            ST_BOOST: begin
                // Leave on handshake or on withdrawal; there is deliberately no timeout.
                if (!bus.req[sel_q] || bus.net_gnt[sel_q]) begin
                    state_d = ST_NORMAL;
                    ptr_d   = sel_q + IdxWidth'(1);
                end else begin
                    state_d = ST_BOOST;
                end
            end
            default: begin
                state_d = ST_NORMAL;
            end
        endcase
    end

    // State registers; asynchronous reset also drops any active mask at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_NORMAL;
            sel_q       <= '0;
            ptr_q       <= '0;
            rr_q        <= '0;
            boost_cnt_q <= 16'd0;
            for (int i = 0; i < NumIn; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            rr_q        <= rr_d;
            boost_cnt_q <= boost_cnt_d;
            for (int i = 0; i < NumIn; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign rr_o        = cfg_fix_en_i ? cfg_rr_i : rr_q;
    assign boost_o     = (state_q == ST_BOOST);
    assign boost_idx_o = sel_q;
    assign boost_cnt_o = boost_cnt_q;

endmodule

// File: tb/tb_tcdm_starve_sched.sv
// Directed bench for tcdm_starve_sched: stimulus pushes expected values into a
// queue, a monitor pops and compares them on each falling clock edge.
module tb_tcdm_starve_sched;

    localparam int NI = 32;
    localparam int NO = 32;
    localparam int TH = 3;
    localparam int RW = 5;
    localparam int IW = 5;

    typedef enum int {K_NREQ, K_GNT, K_BOOST, K_IDX, K_BCNT, K_RR} kind_e;
    typedef struct {
        kind_e       kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic [NI-1:0] allow;
    logic          cfg_fix_en;
    logic [RW-1:0] cfg_rr;
    logic [RW-1:0] rr;
    logic          boost;
    logic [IW-1:0] boost_idx;
    logic [15:0]   boost_cnt;

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    tcdm_starve_sched_if #(.NumIn(NI), .NumOut(NO)) bus ();

    // Network model: grants whatever reaches it and is allowed this cycle.
    assign bus.net_gnt = bus.net_req & allow;

    tcdm_starve_sched #(
        .NumIn(NI), .NumOut(NO), .StarveThresh(TH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .bus          (bus),
        .cfg_fix_en_i (cfg_fix_en),
        .cfg_rr_i     (cfg_rr),
        .rr_o         (rr),
        .boost_o      (boost),
        .boost_idx_o  (boost_idx),
        .boost_cnt_o  (boost_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
    endtask

    task automatic chk(input logic [31:0] act, input logic [31:0] exp_v, input string n);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", n, act, exp_v, $time);
        end
    endtask

    task automatic ex(input kind_e k, input logic [31:0] v, input string n);
        exp_t e;
        e.kind = k;
        e.val  = v;
        e.name = n;
        q.push_back(e);
    endtask

    task automatic ex_st(input logic b, input logic [31:0] idx, input logic [31:0] nreq,
                         input logic [31:0] gnt, input string tag);
        ex(K_BOOST, {31'd0, b}, {tag, ".boost"});
        ex(K_IDX, idx, {tag, ".idx"});
        ex(K_NREQ, nreq, {tag, ".net_req"});
        ex(K_GNT, gnt, {tag, ".gnt"});
    endtask

    // Monitor: compares every queued expectation against the DUT at the falling edge.
    initial begin : mon
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                case (e.kind)
                    K_NREQ:  act = bus.net_req;
                    K_GNT:   act = bus.gnt;
                    K_BOOST: act = {31'd0, boost};
                    K_IDX:   act = {27'd0, boost_idx};
                    K_BCNT:  act = {16'd0, boost_cnt};
                    K_RR:    act = {27'd0, rr};
                    default: act = 32'hxxxx_xxxx;
                endcase
                checks++;
                if (act !== e.val) begin
                    failures++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, act, e.val, $time);
                end
            end
        end
    end

    initial begin
        // Reset state and unstarved traffic with everything granted.
        rst_ni      = 1'b0;
        bus.req     = '1;
        allow       = '1;
        bus.slv_req = '1;
        bus.slv_gnt = '1;
        cfg_fix_en  = 1'b0;
        cfg_rr      = 5'd0;
        step();
        chk({31'd0, boost}, 32'd0, "rst.boost_direct");
        chk(bus.net_req, 32'hFFFF_FFFF, "rst.net_req_direct");
        ex_st(1'b0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "rst");
        ex(K_RR, 32'd0, "rst.rr");
        ex(K_BCNT, 32'd0, "rst.bcnt");
        step();
        rst_ni = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ex(K_RR, 32'(k), "t1.rr");
            ex_st(1'b0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t1");
            step();
        end

        // Master 5 never granted by the network until it is boosted.
        bus.req = 32'h0000_003F;
        allow   = 32'h0000_001F;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            ex_st(1'b0, 32'd0, 32'h3F, 32'h1F, "t2.norm");
            ex(K_RR, 32'(c), "t2.rr");
            step();
        end
        allow = 32'h0000_003F;
        chk({31'd0, boost}, 32'd1, "t2.expired_boost");
        chk({27'd0, boost_idx}, 32'd5, "t2.expired_idx");
        ex_st(1'b1, 32'd5, 32'h20, 32'h20, "t2.boost");
        ex(K_BCNT, 32'd1, "t2.bcnt");
        ex(K_RR, 32'd4, "t2.rr_frozen");
        step();
        allow = 32'h0000_001F;
        ex_st(1'b0, 32'd5, 32'h3F, 32'h1F, "t2.exit");
        ex(K_BCNT, 32'd1, "t2.bcnt_hold");
        ex(K_RR, 32'd4, "t2.rr_after");
        step();
        ex(K_RR, 32'd5, "t2.rr_resume");
        ex(K_BOOST, 32'd0, "t2.normal");
        step();

        // Masters 2 and 7 starve together; then 6 and 9 probe the rotated pointer.
        bus.req = 32'h0000_0084;
        allow   = 32'h0;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            ex_st(1'b0, 32'd0, 32'h84, 32'h0, "t3.norm");
            step();
        end
        allow = 32'h0000_0004;
        ex_st(1'b1, 32'd2, 32'h04, 32'h04, "t3.boost2");
        step();
        bus.req = 32'h0000_0080;
        allow   = 32'h0;
        ex_st(1'b0, 32'd2, 32'h80, 32'h0, "t3.gap");
        step();
        allow = 32'h0000_0080;
        ex_st(1'b1, 32'd7, 32'h80, 32'h80, "t3.boost7");
        ex(K_BCNT, 32'd2, "t3.bcnt2");
        step();
        bus.req = 32'h0000_0240;
        allow   = 32'h0;
        ex_st(1'b0, 32'd7, 32'h240, 32'h0, "t3.after");
        step();
        for (int c = 0; c < 3; c++) begin
            ex(K_BOOST, 32'd0, "t3.wait");
            step();
        end
        ex(K_BOOST, 32'd1, "t3.ptr_boost");
        ex(K_IDX, 32'd9, "t3.ptr_idx");
        ex(K_NREQ, 32'h200, "t3.ptr_nreq");
        ex(K_BCNT, 32'd3, "t3.bcnt3");
        step();

        // Boosted master withdraws its request mid-BOOST.
        bus.req = 32'h0000_0002;
        allow   = 32'h0;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            ex(K_BOOST, 32'd0, "t4.norm");
            step();
        end
        bus.req = 32'h0;
        ex_st(1'b1, 32'd1, 32'h0, 32'h0, "t4.drop");
        step();
        bus.req = 32'h0000_0002;
        ex(K_BOOST, 32'd0, "t4.exit");
        step();
        for (int c = 0; c < 3; c++) begin
            ex(K_BOOST, 32'd0, "t4.cnt0");
            step();
        end
        ex(K_BOOST, 32'd1, "t4.reboost");
        ex(K_BCNT, 32'd2, "t4.bcnt");
        step();

        // Fixed priority override while the internal counter keeps running.
        bus.req    = 32'h0;
        cfg_fix_en = 1'b1;
        cfg_rr     = 5'h1A;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            ex(K_RR, 32'h1A, "t5.fix");
            step();
        end
        cfg_fix_en = 1'b0;
        ex(K_RR, 32'd3, "t5.count");
        step();

        // Asynchronous reset in the middle of a BOOST.
        bus.req = 32'h0000_0008;
        allow   = 32'h0;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step();
        end
        ex_st(1'b1, 32'd3, 32'h08, 32'h0, "t6.boost");
        ex(K_RR, 32'd4, "t6.rr");
        ex(K_BCNT, 32'd1, "t6.bcnt");
        step();
        ex(K_BOOST, 32'd1, "t6.hold");
        step();
        #1;
        rst_ni = 1'b0;
        ex_st(1'b0, 32'd0, 32'h08, 32'h0, "t6.arst");
        ex(K_BCNT, 32'd0, "t6.arst_bcnt");
        ex(K_RR, 32'd0, "t6.arst_rr");
        step();
        step();
        rst_ni = 1'b1;
        for (int c = 0; c < 4; c++) begin
            ex(K_BOOST, 32'd0, "t6.post");
            step();
        end
        ex(K_BOOST, 32'd1, "t6.reboost");
        step();

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tcdm_starve_sched.md
# tcdm_starve_sched

Request scheduler placed between the TCDM masters and a butterfly interconnect instance configured with external priority (`ExtPrio = 1`). It does two things:
- Drives the network's shared arbitration-priority vector.
- Guarantees forward progress: it tracks how long each master's request stays ungranted and, when a master starves, masks all other masters until the starving one is granted.

It gates only `req`/`gnt`. Address and write data go straight from the masters to the network.

## Interface
- `NumIn`, 32: number of masters; power of 2, at least 2.
- `NumOut`, 32: number of banks; power of 2, at least `NumIn`. `RrWidth = $clog2(NumOut)`.
- `StarveThresh`, 15: consecutive ungranted request cycles that mark a master as starving; range 1..255. `CntWidth = $clog2(StarveThresh+1)`.

- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `req_i`  in  `NumIn`  master request.
- `gnt_o`  out  `NumIn`  grant to the masters; `net_gnt_i & ~mask`.
- `net_req_o`  out  `NumIn`  request to the network; `req_i & ~mask`.
- `net_gnt_i`  in  `NumIn`  grant from the network; combinational on `net_req_o`.
- `slv_req_i`  in  `NumOut`  observed network bank-side request.
- `slv_gnt_i`  in  `NumOut`  observed bank grant.
- `cfg_fix_en_i`  in  1  when 1, `rr_o` equals `cfg_rr_i`.
- `cfg_rr_i`  in  `RrWidth`  fixed priority value.
- `rr_o`  out  `RrWidth`  priority vector to the network's `rr_i`.
- `boost_o`  out  1  scheduler is in BOOST state.
- `boost_idx_o`  out  `$clog2(NumIn)`  master currently boosted.
- `boost_cnt_o`  out  16  number of BOOST entries; saturates at 0xFFFF.

## Operation
- **Wait counters**
  - `cnt_q[i]` holds `CntWidth` bits per master.
  - Next value: `cnt_q[i]+1` if `req_i[i] & ~gnt_o[i]`, saturating at `StarveThresh`; otherwise 0.
  - Counters keep running in both states, so a masked master accumulates wait time.
- **Starving set**: `starve[i] = (cnt_q[i] == StarveThresh) & req_i[i]`.
- **Two-state FSM (NORMAL, BOOST)**
  - **NORMAL**: `mask = 0`.
    - If `|starve`, select `sel` = first set bit of `starve` searching upward from `ptr_q`, wrapping modulo `NumIn`.
    - Register `sel_q <= sel`; next state is BOOST; `boost_cnt_o` increments (saturating).
  - **BOOST**: `mask = ~onehot(sel_q)`; only master `sel_q` reaches the network.
  - **Exit from BOOST** (next state NORMAL, `ptr_q <= sel_q+1` mod `NumIn`) when either:
    - `req_i[sel_q] & net_gnt_i[sel_q]` (handshake), or
    - `!req_i[sel_q]` (request withdrawn).
  - BOOST has no timeout. Progress depends on bank `gnt`.
  - Back-to-back BOOSTs take at least one NORMAL cycle between them.
- **Priority generation**
  - `rr_q` is an `RrWidth`-bit counter that increments (wrapping) in every cycle with `|(slv_req_i & slv_gnt_i)` while in NORMAL.
  - `rr_q` holds during BOOST.
  - `rr_o = cfg_fix_en_i ? cfg_rr_i : rr_q`. `cfg_fix_en_i` takes effect combinationally and does not alter `rr_q`.
- **Simultaneous events**
  - Several masters can reach the threshold in the same cycle; only one is selected, and the others stay starving for later rounds.
  - A master whose count reaches threshold in the same cycle it is granted: its counter clears to 0, and it is not starving next cycle.
- **Status outputs**: `boost_o = (state == BOOST)`; `boost_idx_o = sel_q`.
- **Reset values (asynchronous)**
  - state NORMAL; `cnt_q`, `sel_q`, `ptr_q`, `rr_q`, `boost_cnt_o` all 0.
  - Consequently `boost_o = 0`, `boost_idx_o = 0`, and `net_req_o`/`gnt_o` track the inputs unmasked.
  - Reset during BOOST drops the mask immediately, asynchronously.

## Timing
- `net_req_o`, `gnt_o` and `rr_o` are combinational. The mask comes only from registered state, so there is no loop through `net_gnt_i`.
- Reference case: master m requests continuously from cycle 0 and is never granted.
  - `cnt_q[m] == StarveThresh` at cycle `StarveThresh`.
  - The selection is registered at the end of that cycle.
  - The mask is active from cycle `StarveThresh+1`.
  - m is granted at `StarveThresh+1` if its bank grants.
  - NORMAL resumes at `StarveThresh+2`.
- Added latency for unstarved traffic is zero cycles.

## Test plan
- Reset with `req_i` held at all-ones and the network granting all requests: `net_req_o` equals all-ones, `boost_o` stays 0, and `rr_o` increments by 1 per cycle.
- `StarveThresh = 3`; master 5 requests, its `net_gnt` is forced to 0 until masked, and masters 0–4 request the same bank: `boost_o = 1`, `boost_idx_o = 5` at cycle 4, `net_req_o = 0x20`, and `gnt_o[5] = 1` in cycle 4; `boost_o = 0` at cycle 5; `boost_cnt_o = 1`.
- Masters 2 and 7 starve in the same cycle with `ptr_q = 0`: 2 is boosted first, then 7 after one NORMAL cycle, with `ptr_q = 8` afterwards.
- Boosted master drops `req` mid-BOOST: return to NORMAL next cycle with no grant issued, and its counter reads 0.
- `cfg_fix_en_i = 1`, `cfg_rr_i = 0x1A`: `rr_o = 0x1A` while `rr_q` keeps counting. During BOOST, `rr_q` is frozen and resumes counting afterwards.
- Assert `rst_ni` mid-BOOST: mask, `boost_o` and all counters go to 0 asynchronously, and `boost_cnt_o` reads 0.
